// File: rtl/aes_encryption_256_iterative.sv
// Iterative AES-256 encryption core: one cipher round per clock with
// on-the-fly key expansion and valid/ready handshakes on both sides.
module aes_encryption_256_iterative (
    input  logic         CLK,
    input  logic         RST,
    input  logic         IN_VALID,
    output logic         IN_READY,
    input  logic [0:127] PLAIN_DATA,
    input  logic [0:255] CIPHER_KEY,
    output logic         OUT_VALID,
    input  logic         OUT_READY,
    output logic [0:127] ENCRYPTED_DATA
);

    typedef enum logic [1:0] {IDLE, ROUND, DONE} state_t;

    // Byte x of the table lives at bits [8*(255-x) +: 8], i.e. entry 0 is the MSB byte.
    localparam logic [2047:0] SBOX = {
        128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
    };

    state_t        state;
    state_t        state_next;
    logic [127:0]  st;
    logic [255:0]  kw;
    logic [3:0]    rnd;
    logic [127:0]  enc_q;
    logic          out_vld;
    logic [127:0]  new_words;
    logic [127:0]  rk;
    logic [127:0]  round_out;

    function automatic logic [7:0] sbox(input logic [7:0] b);
        return SBOX[{~b, 3'b000} +: 8];
    endfunction

    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [31:0] sub_word(input logic [31:0] w);
        return {sbox(w[31:24]), sbox(w[23:16]), sbox(w[15:8]), sbox(w[7:0])};
    endfunction

    // Next four schedule words from the 8-word window; even rounds rotate and add Rcon.
    function automatic logic [127:0] expand_key(input logic [255:0] k, input logic [3:0] r);
        logic [31:0] temp;
        logic [31:0] n0, n1, n2, n3;
        logic [7:0]  rcon;
        rcon = 8'h01 << (r[3:1] - 3'd1);
        if (!r[0])
            temp = sub_word({k[23:0], k[31:24]}) ^ {rcon, 24'h000000};
        else
            temp = sub_word(k[31:0]);
        n0 = k[255:224] ^ temp;
        n1 = k[223:192] ^ n0;
        n2 = k[191:160] ^ n1;
        n3 = k[159:128] ^ n2;
        return {n0, n1, n2, n3};
    endfunction

    // SubBytes, ShiftRows and (except in the last round) MixColumns; key added by caller.
    function automatic logic [127:0] cipher_round(input logic [127:0] s, input logic last);
        logic [7:0]   b [16];
        logic [7:0]   t [16];
        logic [7:0]   a0, a1, a2, a3;
        logic [127:0] r;
        for (int i = 0; i < 16; i++)
            b[i] = sbox(s[127-8*i -: 8]);
        for (int c = 0; c < 4; c++)
            for (int rr = 0; rr < 4; rr++)
                t[rr+4*c] = b[rr+4*((c+rr)%4)];
        for (int c = 0; c < 4; c++) begin
            a0 = t[4*c];
            a1 = t[4*c+1];
            a2 = t[4*c+2];
            a3 = t[4*c+3];
            if (!last) begin
                r[127-32*c -: 8]  = xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3;
                r[119-32*c -: 8]  = a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3;
                r[111-32*c -: 8]  = a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3;
                r[103-32*c -: 8]  = xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3);
            end else begin
                r[127-32*c -: 32] = {a0, a1, a2, a3};
            end
        end
        return r;
    endfunction

    // Round datapath: expansion, round key select and the full round, all combinational.
    assign new_words = expand_key(kw, rnd);
    assign rk        = (rnd == 4'd1) ? kw[127:0] : new_words;
    assign round_out = cipher_round(st, rnd == 4'd14) ^ rk;

    assign OUT_VALID      = out_vld;
    assign ENCRYPTED_DATA = enc_q;

    // State register.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) state <= IDLE;
        else     state <= state_next;
    end

    // Next-state logic and input-side ready.
    always_comb begin
        state_next = state;
        IN_READY   = 1'b0;
        case (state)
            IDLE: begin
                IN_READY = 1'b1;
                if (IN_VALID) state_next = ROUND;
            end
            ROUND:   if (rnd == 4'd14) state_next = DONE;
            DONE:    if (OUT_READY) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Cipher state, key window, round counter and result/valid registers.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            st      <= '0;
            kw      <= '0;
            rnd     <= '0;
            enc_q   <= '0;
            out_vld <= 1'b0;
        end else begin
            case (state)
                IDLE: if (IN_VALID) begin
                    st  <= PLAIN_DATA ^ CIPHER_KEY[0:127];
                    kw  <= CIPHER_KEY;
                    rnd <= 4'd1;
                end
                ROUND: begin
                    st  <= round_out;
                    rnd <= rnd + 4'd1;
                    if (rnd != 4'd1) kw <= {kw[127:0], new_words};
                    if (rnd == 4'd14) begin
                        enc_q   <= round_out;
                        out_vld <= 1'b1;
                    end
                end
                DONE: if (OUT_READY) out_vld <= 1'b0;
                default: ;
            endcase
        end
    end

endmodule
